timer_port_arb: RTL and testbench
=================================

// Module: timer_port_arb
// PURPOSE
//  Shares the timer's single register access port (mtime @0x00, mtimecmp @0x04) between N_REQ requesters
//  (e.g. core LSU and debug unit). Round-robin grant, one transaction in flight.
//  Each accepted command becomes exactly one timer_wr_en_o or timer_rd_en_o strobe.
//  The response (read data / error) is returned registered to the winning requester.
// PARAMETERS
//  N_REQ   2   number of requesters (>=2)
//  ADDR_W  20  timer register address width
//  DATA_W  32  data width
// PORTS
//  clk_i            in   1              single clock, all state updates on posedge
//  rst_i            in   1              synchronous, active-high reset
//  req_valid_i      in   N_REQ          per-requester command valid
//  req_we_i         in   N_REQ          1 = write, 0 = read
//  req_addr_i       in   N_REQ*ADDR_W   requester k at bits [k*ADDR_W +: ADDR_W]
//  req_wdata_i      in   N_REQ*DATA_W   requester k at bits [k*DATA_W +: DATA_W]
//  req_ready_o      out  N_REQ          one-hot accept pulse
//  rsp_valid_o      out  N_REQ          one-hot response pulse
//  rsp_rdata_o      out  DATA_W         read data, valid with rsp_valid_o
//  rsp_err_o        out  1              unmapped/misaligned address, valid with rsp_valid_o
//  timer_wr_en_o    out  1              timer write strobe
//  timer_wr_addr_o  out  ADDR_W         timer write address
//  timer_wr_data_o  out  DATA_W         timer write data
//  timer_rd_en_o    out  1              timer read strobe
//  timer_rd_addr_o  out  ADDR_W         timer read address
//  timer_rd_data_i  in   DATA_W         combinational read data from timer
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0; all outputs 0; latched command cleared.
//  FSM:
//   IDLE: if any req_valid_i, pick winner w = first valid index at or after rr_ptr (modulo N_REQ).
//         Same cycle: req_ready_o[w]=1; latch we/addr/wdata; rr_ptr<=(w+1)%N_REQ; ->ISSUE.
//         No valid: stay IDLE, rr_ptr unchanged.
//   ISSUE: addr is 0x00 or 0x04: drive exactly one strobe (wr or rd) with the latched addr/data.
//          On rd, capture timer_rd_data_i at cycle end. ->RESP.
//          addr is any other value: no strobe; err flag set; rdata=0. ->RESP.
//   RESP: rsp_valid_o[w]=1, rsp_rdata_o and rsp_err_o registered. ->IDLE.
//  Timing: accept at T, strobe at T+1, response at T+2. Max 1 transaction per 3 cycles.
//  Strobe outputs: registered, asserted only in ISSUE, never both together.
//   Addr/data outputs are 0 when no strobe.
//  Write response: rsp_rdata_o=0, rsp_err_o=0 for valid addresses.
//  Handshake:
//   - Requester holds valid and payload stable until ready.
//   - Valid dropped before ready: no transaction occurs, no response.
//   - A requester must not issue a new command before its rsp_valid_o.
//  Simultaneous valids: exactly one ready per grant; losers wait with no side effects.
//   Under continuous load, grants rotate fairly: no requester waits more than N_REQ-1 grants.
//  rr_ptr wraps N_REQ-1 -> 0.
//  Reset mid-operation (ISSUE or RESP): transaction aborted; no strobe or response is issued.
//   A strobe registered for the reset cycle is suppressed.
//  rsp_valid_o and req_ready_o are never asserted in the same cycle for the same requester.
// STRUCTURE
//  Shared header timer_defs.vh:
//   - TIMER_MTIME_ADDR=20'h00, TIMER_MTIMECMP_ADDR=20'h04.
//   - FSM state encodings (IDLE/ISSUE/RESP).
//   - Reused by the timer and the bus decoder.
//  Sub-module rr_pick: combinational round-robin picker.
//   - In: valid[N_REQ], ptr. Out: one-hot grant, index, any.
//   - Reusable for other shared peripherals.
//  Top: FSM, command latch, response registers.
// TESTING
//  1. After reset, req0 reads 0x04 at T -> ready[0]@T, rd_en/addr=0x04 @T+1, rsp_valid[0]@T+2,
//     rdata=FFFF_FFFF, err=0.
//  2. req1 writes 0x0000_1234 to 0x00 -> one wr_en cycle, wr_data=0x1234.
//     rsp_valid[1], err=0; a later read of 0x00 returns >=0x1234.
//  3. req0 and req1 continuously valid for 6 grants -> ready order 0,1,0,1,0,1.
//     No cycle has both strobes set.
//  4. req0 reads 0x08 -> no timer strobe; rsp_valid[0], err=1, rdata=0.
//  5. Reset in ISSUE -> no strobe or response; all outputs 0.
//     With both requesters valid afterwards, the next grant goes to req0 (rr_ptr=0).
//  6. N_REQ=3, valids {0,2} with rr_ptr=1 -> grant req2, then req0; req1 raising valid later
//     is granted within 2 grants.

Source files
------------

// File: rtl/timer_port_arb_pkg.sv
// timer_port_arb_pkg: timer register map and arbiter FSM encodings, shared with the timer and bus decoder
package timer_port_arb_pkg;
    localparam logic [19:0] TIMER_MTIME_ADDR    = 20'h00;
    localparam logic [19:0] TIMER_MTIMECMP_ADDR = 20'h04;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;
    // Zero-extended compare so any upper address bits make the access unmapped
    function automatic logic timer_addr_ok(input logic [63:0] addr);
        return addr == 64'(TIMER_MTIME_ADDR) || addr == 64'(TIMER_MTIMECMP_ADDR);
    endfunction
endpackage

// File: rtl/timer_port_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index at or after ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (valid[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        any   = |valid;
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/timer_port_arb.sv
// timer_port_arb: round-robin sharing of the timer register port, one transaction in flight
module timer_port_arb
    import timer_port_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    timer_wr_en_o,
    output logic [ADDR_W-1:0]       timer_wr_addr_o,
    output logic [DATA_W-1:0]       timer_wr_data_o,
    output logic                    timer_rd_en_o,
    output logic [ADDR_W-1:0]       timer_rd_addr_o,
    input  logic [DATA_W-1:0]       timer_rd_data_i
);
    localparam int IW = $clog2(N_REQ);
    state_t            state;
    logic [IW-1:0]     rr_ptr, pick_idx, win;
    logic [N_REQ-1:0]  pick_oh, rsp_valid_q;
    logic              pick_any, accept, pick_we, pick_ok;
    logic [ADDR_W-1:0] pick_addr, addr_q;
    logic [DATA_W-1:0] pick_wdata, wdata_q, rdata_q;
    logic              wr_q, rd_q, err_q, rsp_err_q;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .valid(req_valid_i),
        .ptr  (rr_ptr),
        .grant(pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign accept      = !rst_i && state == ST_IDLE && pick_any;
    assign pick_we     = req_we_i[pick_idx];
    assign pick_addr   = req_addr_i[int'(pick_idx) * ADDR_W +: ADDR_W];
    assign pick_wdata  = req_wdata_i[int'(pick_idx) * DATA_W +: DATA_W];
    assign pick_ok     = timer_addr_ok(64'(pick_addr));
    assign req_ready_o = accept ? pick_oh : '0;

    // Strobes are decided at accept so they are registered going into ISSUE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= accept ? ST_ISSUE : state == ST_ISSUE ? ST_RESP : ST_IDLE;
            wr_q        <= accept && pick_ok && pick_we;
            rd_q        <= accept && pick_ok && !pick_we;
            rsp_valid_q <= state == ST_ISSUE ? N_REQ'(1) << win : '0;
            rdata_q     <= rd_q ? timer_rd_data_i : '0;
            rsp_err_q   <= state == ST_ISSUE && err_q;
            if (accept) begin
                win     <= pick_idx;
                addr_q  <= pick_addr;
                wdata_q <= pick_wdata;
                err_q   <= !pick_ok;
                rr_ptr  <= pick_idx == IW'(N_REQ - 1) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // Gating with rst_i kills anything registered for the reset cycle itself
    assign timer_wr_en_o   = wr_q && !rst_i;
    assign timer_rd_en_o   = rd_q && !rst_i;
    assign timer_wr_addr_o = timer_wr_en_o ? addr_q : '0;
    assign timer_wr_data_o = timer_wr_en_o ? wdata_q : '0;
    assign timer_rd_addr_o = timer_rd_en_o ? addr_q : '0;
    assign rsp_valid_o     = rst_i ? '0 : rsp_valid_q;
    assign rsp_rdata_o     = rst_i ? '0 : rdata_q;
    assign rsp_err_o       = rsp_err_q && !rst_i;
endmodule

// File: tb/tb_timer_port_arb.sv
// tb_timer_port_arb: directed checks of timer_port_arb with a small timer model
module tb_timer_port_arb;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_valid = '0, req_we = '0;
    logic [39:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata, wr_data, rd_data;
    logic        rsp_err, wr_en, rd_en;
    logic [19:0] wr_addr, rd_addr;
    logic [31:0] mtime, mtimecmp;
    logic [2:0]  v3 = '0, r3_ready, r3_rsp;
    logic [31:0] r3_rdata, r3_wdata;
    logic        r3_err, r3_wr, r3_rd;
    logic [19:0] r3_waddr, r3_raddr;
    int          n_chk = 0, n_fail = 0, got;

    always #5 clk_i = ~clk_i;

    timer_port_arb dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .timer_wr_en_o(wr_en), .timer_wr_addr_o(wr_addr), .timer_wr_data_o(wr_data),
        .timer_rd_en_o(rd_en), .timer_rd_addr_o(rd_addr), .timer_rd_data_i(rd_data)
    );

    timer_port_arb #(.N_REQ(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(v3), .req_we_i(3'b000),
        .req_addr_i(60'd0), .req_wdata_i(96'd0), .req_ready_o(r3_ready),
        .rsp_valid_o(r3_rsp), .rsp_rdata_o(r3_rdata), .rsp_err_o(r3_err),
        .timer_wr_en_o(r3_wr), .timer_wr_addr_o(r3_waddr), .timer_wr_data_o(r3_wdata),
        .timer_rd_en_o(r3_rd), .timer_rd_addr_o(r3_raddr), .timer_rd_data_i(32'd0)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            mtime <= (wr_en && wr_addr == 20'h0) ? wr_data : mtime + 1;
            if (wr_en && wr_addr == 20'h4) mtimecmp <= wr_data;
        end
    end
    assign rd_data = rd_addr == 20'h4 ? mtimecmp : mtime;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [19:0] a, input logic [31:0] d);
        req_valid[k]         = 1'b1;
        req_we[k]            = we;
        req_addr[k*20 +: 20] = a;
        req_wdata[k*32 +: 32] = d;
    endtask

    task automatic wait_rdy3(input string tag, input logic [2:0] exp);
        int c = 0;
        while (r3_ready === 3'b000 && c < 8) begin
            cyc();
            c++;
        end
        chk(tag, r3_ready, exp);
    endtask

    initial begin
        cyc();
        chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, wr_en, rd_en, wr_addr, rd_addr, wr_data}, '0);
        cyc();
        // 1: req0 reads mtimecmp
        rst_i = 1'b0;
        set_req(0, 1'b0, 20'h4, 32'h0);
        #1 chk("t1_ready", req_ready, 2'b01);
        chk("t1_no_strobe_T", {wr_en, rd_en}, 2'b00);
        cyc();
        req_valid = '0;
        chk("t1_rd_en", {rd_en, wr_en, req_ready}, 4'b1000);
        chk("t1_rd_addr", rd_addr, 20'h4);
        cyc();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rdata", rsp_rdata, 32'hFFFF_FFFF);
        chk("t1_err", rsp_err, 1'b0);
        cyc();
        chk("t1_rsp_done", rsp_valid, 2'b00);
        // 2: req1 writes mtime, then reads it back
        set_req(1, 1'b1, 20'h0, 32'h1234);
        #1 chk("t2_ready", req_ready, 2'b10);
        cyc();
        req_valid = '0;
        chk("t2_wr_en", {wr_en, rd_en}, 2'b10);
        chk("t2_wr_addr", wr_addr, 20'h0);
        chk("t2_wr_data", wr_data, 32'h1234);
        cyc();
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        chk("t2_rsp", {rsp_err, rsp_rdata}, 33'h0);
        chk("t2_one_wr", wr_en, 1'b0);
        cyc();
        set_req(1, 1'b0, 20'h0, 32'h0);
        #1 chk("t2_rd_ready", req_ready, 2'b10);
        cyc();
        req_valid = '0;
        cyc();
        chk("t2_rd_rsp", rsp_valid, 2'b10);
        chk("t2_rd_ge", rsp_rdata >= 32'h1234 && rsp_rdata < 32'h1240, 1'b1);
        cyc();
        // 3: both requesters continuously valid
        set_req(0, 1'b0, 20'h0, 32'h0);
        set_req(1, 1'b0, 20'h4, 32'h0);
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            #1 chk("t3_strobes_excl", wr_en && rd_en, 1'b0);
            if (req_ready != 2'b00) begin
                chk("t3_order", req_ready, got % 2 == 0 ? 2'b01 : 2'b10);
                got++;
            end
            cyc();
        end
        chk("t3_grants", got, 6);
        req_valid = '0;
        cyc();
        cyc();
        // 4: unmapped address
        set_req(0, 1'b0, 20'h8, 32'h0);
        #1 chk("t4_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        chk("t4_no_strobe", {wr_en, rd_en, rd_addr}, '0);
        cyc();
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_err", rsp_err, 1'b1);
        chk("t4_rdata", rsp_rdata, 32'h0);
        cyc();
        // 5: reset while in ISSUE
        set_req(0, 1'b0, 20'h4, 32'h0);
        #1 chk("t5_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        rst_i = 1'b1;
        #1 chk("t5_strobe_killed", {wr_en, rd_en, rd_addr, rsp_valid}, '0);
        cyc();
        chk("t5_no_rsp", {rsp_valid, rsp_rdata, rsp_err, req_ready}, '0);
        rst_i = 1'b0;
        set_req(0, 1'b0, 20'h0, 32'h0);
        set_req(1, 1'b0, 20'h0, 32'h0);
        #1 chk("t5_ptr_reset", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        chk("t5_rd_en", rd_en, 1'b1);
        cyc();
        chk("t5_rsp", rsp_valid, 2'b01);
        cyc();
        // 6: three requesters, rr_ptr moved to 1 first
        v3 = 3'b001;
        #1 chk("t6_first", r3_ready, 3'b001);
        cyc();
        v3 = 3'b000;
        cyc();
        chk("t6_rsp0", r3_rsp, 3'b001);
        cyc();
        v3 = 3'b101;
        #1 chk("t6_grant2", r3_ready, 3'b100);
        cyc();
        v3 = 3'b011;
        wait_rdy3("t6_grant0", 3'b001);
        cyc();
        v3 = 3'b010;
        wait_rdy3("t6_grant1", 3'b010);
        cyc();
        v3 = 3'b000;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
